// File: rtl/mpc_refill_buffer_pkg.sv
// ---------------------------------------------------------------------------
// mpc_refill_buffer_pkg
// Purpose : shared cache/memory op encodings, line meta states, the refill
//           buffer per-entry state type and the op -> meta mapping used when
//           a completed line is returned to the cache pipeline.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package mpc_refill_buffer_pkg;

  typedef enum logic [2:0] {
    CACHE_OP_NOP          = 3'd0,
    CACHE_OP_LOAD         = 3'd1,
    CACHE_OP_STORE        = 3'd2,
    CACHE_OP_LOAD_REFILL  = 3'd3,
    CACHE_OP_STORE_REFILL = 3'd4
  } mpc_cache_op_e;

  typedef enum logic [2:0] {
    MEM_OP_NONE  = 3'd0,
    MEM_OP_LOAD  = 3'd1,
    MEM_OP_STORE = 3'd2
  } mpc_mem_op_e;

  typedef enum logic [1:0] {
    MPC_META_INVALID = 2'd0,
    MPC_META_SHARE   = 2'd1,
    MPC_META_UNIQUE  = 2'd2,
    MPC_META_DIRTY   = 2'd3
  } mpc_meta_e;

  // FREE must stay the all-zero encoding: reset clears whole entries to '0.
  typedef enum logic [1:0] {
    RFBUF_FREE = 2'd0,
    RFBUF_REQ  = 2'd1,
    RFBUF_WAIT = 2'd2,
    RFBUF_FULL = 2'd3
  } rfbuf_state_e;

  // A store refill grants ownership of the line; anything else is shared.
  function automatic mpc_meta_e refill_meta(input logic [2:0] op);
    if (op == CACHE_OP_STORE_REFILL) return MPC_META_UNIQUE;
    return MPC_META_SHARE;
  endfunction

endpackage

// File: rtl/mpc_refill_buffer_prio_enc.sv
// ---------------------------------------------------------------------------
// mpc_rfbuf_prio_enc
// Purpose : lowest-set-bit priority encoder, used by the refill buffer to
//           pick the lowest-index entry for allocation, issue and drain.
// Ports   : req_i    [N]   candidate vector
//           onehot_o [N]   lowest set bit of req_i (0 when none)
//           idx_o    [IW]  index of that bit (0 when none)
//           any_o          req_i has at least one bit set
// ---------------------------------------------------------------------------
module mpc_rfbuf_prio_enc #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    onehot_o = req_i & (~req_i + N'(1));
    idx_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/mpc_refill_buffer.sv
// ---------------------------------------------------------------------------
// mpc_refill_buffer
// Purpose : miss-handling stage between the cache tag/data pipeline and the
//           memory controller. Accepts load/store refill requests, issues
//           MEM_OP_LOAD line reads, assembles the multi-beat response into a
//           full cacheline and returns it with its victim way and meta state.
// Ports   : clk_i, rst_i (async, active-high)
//           miss_*   : refill request in (valid/ready, op, addr, way)
//           mem_req_*: line read out (valid/ready, op, addr, id)
//           mem_rsp_*: response beats in (valid, id, data, last), no backpressure
//           refill_* : completed line out (valid/ready, op, addr, way, meta, data)
//           lookup_addr_i / lookup_hit_o : probe for an in-flight line
// Config  : define MPC_RFBUF_LOOKUP_EN to build the lookup comparators;
//           otherwise lookup_hit_o is tied low.
// ---------------------------------------------------------------------------
module mpc_refill_buffer
  import mpc_refill_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int CL_WIDTH       = 512,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int RFBUF_SIZE     = 4,
  parameter int WAY_IDX_WIDTH  = 2,
  localparam int ID_W          = $clog2(RFBUF_SIZE)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      miss_valid_i,
  output logic                      miss_ready_o,
  input  logic [2:0]                miss_op_i,
  input  logic [ADDR_WIDTH-1:0]     miss_addr_i,
  input  logic [WAY_IDX_WIDTH-1:0]  miss_way_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [2:0]                mem_req_op_o,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr_o,
  output logic [ID_W-1:0]           mem_req_id_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [ID_W-1:0]           mem_rsp_id_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                      mem_rsp_last_i,
  output logic                      refill_valid_o,
  input  logic                      refill_ready_i,
  output logic [2:0]                refill_op_o,
  output logic [ADDR_WIDTH-1:0]     refill_addr_o,
  output logic [WAY_IDX_WIDTH-1:0]  refill_way_o,
  output logic [1:0]                refill_meta_o,
  output logic [CL_WIDTH-1:0]       refill_data_o,
  input  logic [ADDR_WIDTH-1:0]     lookup_addr_i,
  output logic                      lookup_hit_o
);

  localparam int BEATS = CL_WIDTH / MEM_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'((CL_WIDTH / 8) - 1));

  typedef struct packed {
    rfbuf_state_e             state;
    logic [2:0]               op;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [WAY_IDX_WIDTH-1:0] way;
    logic [CNT_W-1:0]         cnt;
  } entry_t;

  entry_t ent_q [RFBUF_SIZE];
  entry_t ent_d [RFBUF_SIZE];
  logic [CL_WIDTH-1:0] line_data [RFBUF_SIZE];

  logic [RFBUF_SIZE-1:0] free_vec, req_vec, full_vec, free_d_vec, beat_we;
  logic [RFBUF_SIZE-1:0] alloc_oh, issue_oh, drain_oh, issue_sel, drain_sel;
  logic [ID_W-1:0]       issue_idx, drain_idx, mem_req_id, drain_id;
  logic [ID_W-1:0]       unused_alloc_idx;
  logic                  unused_alloc_any, issue_any, drain_any;
  logic                  miss_ready_q;
  logic                  issue_lock_q, drain_lock_q;
  logic [ID_W-1:0]       issue_lock_id_q, drain_lock_id_q;
  logic                  miss_fire, mem_fire, refill_fire;

  always_comb begin
    for (int i = 0; i < RFBUF_SIZE; i++) begin
      free_vec[i] = (ent_q[i].state == RFBUF_FREE);
      req_vec[i]  = (ent_q[i].state == RFBUF_REQ);
      full_vec[i] = (ent_q[i].state == RFBUF_FULL);
      beat_we[i]  = mem_rsp_valid_i && (mem_rsp_id_i == ID_W'(i)) &&
                    (ent_q[i].state == RFBUF_WAIT);
    end
  end

  mpc_rfbuf_prio_enc #(.N(RFBUF_SIZE)) u_alloc_enc (
    .req_i(free_vec), .onehot_o(alloc_oh), .idx_o(unused_alloc_idx), .any_o(unused_alloc_any)
  );
  mpc_rfbuf_prio_enc #(.N(RFBUF_SIZE)) u_issue_enc (
    .req_i(req_vec), .onehot_o(issue_oh), .idx_o(issue_idx), .any_o(issue_any)
  );
  mpc_rfbuf_prio_enc #(.N(RFBUF_SIZE)) u_drain_enc (
    .req_i(full_vec), .onehot_o(drain_oh), .idx_o(drain_idx), .any_o(drain_any)
  );

  // Once a valid has been shown without ready, the chosen entry is locked so
  // a newly eligible lower-index entry cannot change the payload mid-handshake.
  assign mem_req_id      = issue_lock_q ? issue_lock_id_q : issue_idx;
  assign mem_req_valid_o = issue_lock_q | issue_any;
  assign issue_sel       = issue_lock_q ? (RFBUF_SIZE'(1) << issue_lock_id_q) : issue_oh;
  assign drain_id        = drain_lock_q ? drain_lock_id_q : drain_idx;
  assign refill_valid_o  = drain_lock_q | drain_any;
  assign drain_sel       = drain_lock_q ? (RFBUF_SIZE'(1) << drain_lock_id_q) : drain_oh;

  assign miss_ready_o = miss_ready_q;
  assign miss_fire    = miss_valid_i & miss_ready_q;
  assign mem_fire     = mem_req_valid_o & mem_req_ready_i;
  assign refill_fire  = refill_valid_o & refill_ready_i;

  always_comb begin
    for (int i = 0; i < RFBUF_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      unique case (ent_q[i].state)
        RFBUF_FREE: begin
          if (miss_fire && alloc_oh[i]) begin
            ent_d[i].state = RFBUF_REQ;
            ent_d[i].op    = miss_op_i;
            ent_d[i].addr  = miss_addr_i & LINE_MASK;
            ent_d[i].way   = miss_way_i;
            ent_d[i].cnt   = '0;
          end
        end
        RFBUF_REQ: begin
          if (mem_fire && issue_sel[i]) ent_d[i].state = RFBUF_WAIT;
        end
        RFBUF_WAIT: begin
          // The beat counter, not mem_rsp_last_i, decides completion.
          if (beat_we[i]) begin
            if (ent_q[i].cnt == LAST_CNT) begin
              ent_d[i].cnt   = '0;
              ent_d[i].state = RFBUF_FULL;
            end else begin
              ent_d[i].cnt = ent_q[i].cnt + 1'b1;
            end
          end
        end
        RFBUF_FULL: begin
          if (refill_fire && drain_sel[i]) ent_d[i].state = RFBUF_FREE;
        end
        default: ent_d[i] = ent_q[i];
      endcase
      free_d_vec[i] = (ent_d[i].state == RFBUF_FREE);
    end
  end

  // miss_ready is registered from next state so an entry freed by a drain
  // becomes allocatable only in the following cycle, and it is low in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RFBUF_SIZE; i++) ent_q[i] <= '0;
      miss_ready_q    <= 1'b0;
      issue_lock_q    <= 1'b0;
      issue_lock_id_q <= '0;
      drain_lock_q    <= 1'b0;
      drain_lock_id_q <= '0;
    end else begin
      for (int i = 0; i < RFBUF_SIZE; i++) ent_q[i] <= ent_d[i];
      miss_ready_q    <= |free_d_vec;
      issue_lock_q    <= mem_req_valid_o & ~mem_req_ready_i;
      issue_lock_id_q <= mem_req_id;
      drain_lock_q    <= refill_valid_o & ~refill_ready_i;
      drain_lock_id_q <= drain_id;
    end
  end

  for (genvar gi = 0; gi < RFBUF_SIZE; gi++) begin : g_line
    logic [CL_WIDTH-1:0] data_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_q <= '0;
      end else if (beat_we[gi]) begin
        data_q[int'(ent_q[gi].cnt) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rsp_data_i;
      end
    end
    assign line_data[gi] = data_q;
  end

  assign mem_req_op_o   = MEM_OP_LOAD;
  assign mem_req_id_o   = mem_req_id;
  assign mem_req_addr_o = mem_req_valid_o ? ent_q[mem_req_id].addr : '0;

  assign refill_op_o   = refill_valid_o ? ent_q[drain_id].op : 3'd0;
  assign refill_addr_o = refill_valid_o ? ent_q[drain_id].addr : '0;
  assign refill_way_o  = refill_valid_o ? ent_q[drain_id].way : '0;
  assign refill_meta_o = refill_valid_o ? refill_meta(ent_q[drain_id].op) : 2'd0;
  assign refill_data_o = refill_valid_o ? line_data[drain_id] : '0;

`ifdef MPC_RFBUF_LOOKUP_EN
  logic [RFBUF_SIZE-1:0] lookup_vec;
  for (genvar gi = 0; gi < RFBUF_SIZE; gi++) begin : g_lookup
    assign lookup_vec[gi] = (ent_q[gi].state != RFBUF_FREE) &&
                            (ent_q[gi].addr == (lookup_addr_i & LINE_MASK));
  end
  assign lookup_hit_o = |lookup_vec;
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_addr_i;
  assign lookup_hit_o  = 1'b0;
`endif

  // The last marker must agree with the beat counter of the addressed entry.
  logic rsp_in_wait, rsp_is_last;
  assign rsp_in_wait = (ent_q[mem_rsp_id_i].state == RFBUF_WAIT);
  assign rsp_is_last = (ent_q[mem_rsp_id_i].cnt == LAST_CNT);

  a_rsp_last_matches_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_rsp_valid_i && rsp_in_wait) |-> (mem_rsp_last_i == rsp_is_last));

endmodule

// File: tb/tb_mpc_refill_buffer.sv
// ---------------------------------------------------------------------------
// tb_mpc_refill_buffer
// Purpose : self-checking bench for mpc_refill_buffer: reset state, a table
//           of single-line refills, back-to-back fill, interleaved beats,
//           handshake stability, lookup and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_mpc_refill_buffer;
  import mpc_refill_buffer_pkg::*;

  localparam int AW    = 32;
  localparam int CL    = 512;
  localparam int MDW   = 64;
  localparam int N     = 4;
  localparam int WW    = 2;
  localparam int IDW   = 2;
  localparam int BEATS = CL / MDW;

`ifdef MPC_RFBUF_LOOKUP_EN
  localparam logic LK_EN = 1'b1;
`else
  localparam logic LK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           miss_valid = 1'b0;
  logic           miss_ready;
  logic [2:0]     miss_op = 3'd0;
  logic [AW-1:0]  miss_addr = '0;
  logic [WW-1:0]  miss_way = '0;
  logic           mem_req_valid;
  logic           mem_req_ready = 1'b0;
  logic [2:0]     mem_req_op;
  logic [AW-1:0]  mem_req_addr;
  logic [IDW-1:0] mem_req_id;
  logic           mem_rsp_valid = 1'b0;
  logic [IDW-1:0] mem_rsp_id = '0;
  logic [MDW-1:0] mem_rsp_data = '0;
  logic           mem_rsp_last = 1'b0;
  logic           refill_valid;
  logic           refill_ready = 1'b0;
  logic [2:0]     refill_op;
  logic [AW-1:0]  refill_addr;
  logic [WW-1:0]  refill_way;
  logic [1:0]     refill_meta;
  logic [CL-1:0]  refill_data;
  logic [AW-1:0]  lookup_addr = '0;
  logic           lookup_hit;

  always #5 clk = ~clk;

  mpc_refill_buffer #(
    .ADDR_WIDTH(AW), .CL_WIDTH(CL), .MEM_DATA_WIDTH(MDW),
    .RFBUF_SIZE(N), .WAY_IDX_WIDTH(WW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_op_i(miss_op),
    .miss_addr_i(miss_addr), .miss_way_i(miss_way),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_op_o(mem_req_op), .mem_req_addr_o(mem_req_addr), .mem_req_id_o(mem_req_id),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_id_i(mem_rsp_id),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_last_i(mem_rsp_last),
    .refill_valid_o(refill_valid), .refill_ready_i(refill_ready),
    .refill_op_o(refill_op), .refill_addr_o(refill_addr), .refill_way_o(refill_way),
    .refill_meta_o(refill_meta), .refill_data_o(refill_data),
    .lookup_addr_i(lookup_addr), .lookup_hit_o(lookup_hit)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    op;
    logic [WW-1:0] way;
    logic [1:0]    meta;
    logic [CL-1:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [WW-1:0] way;
    logic [31:0]   seed;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_meta;
    int            req_delay;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[5];
  int checks = 0;
  int errors = 0;

  localparam logic [AW-1:0] A0 = 32'h0001_0000, A1 = 32'h0001_0040, A2 = 32'h0001_0080;
  localparam logic [AW-1:0] A3 = 32'h0001_00C0, A4 = 32'h0002_0000, A5 = 32'h0003_0000;

  function automatic logic [MDW-1:0] beat_val(input int id, input logic [31:0] seed, input int b);
    return {seed, 16'(id), 16'(b)};
  endfunction

  function automatic logic [CL-1:0] mk_line(input int id, input logic [31:0] seed);
    logic [CL-1:0] l;
    l = '0;
    for (int b = 0; b < BEATS; b++) l[b*MDW +: MDW] = beat_val(id, seed, b);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int id, input logic [31:0] seed, input int b);
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = IDW'(id);
    mem_rsp_data  = beat_val(id, seed, b);
    mem_rsp_last  = (b == BEATS - 1);
    cyc();
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
  endtask

  task automatic feed_line(input int id, input logic [31:0] seed);
    for (int b = 0; b < BEATS; b++) send_beat(id, seed, b);
  endtask

  task automatic do_miss(input logic [2:0] op, input logic [AW-1:0] addr, input logic [WW-1:0] way);
    for (int i = 0; i < 50 && !miss_ready; i++) cyc();
    chk("miss_ready_wait", miss_ready, 1);
    miss_valid = 1'b1; miss_op = op; miss_addr = addr; miss_way = way;
    cyc();
    miss_valid = 1'b0;
    $display("miss op=%0d addr=%h way=%0d", op, addr, way);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !mem_req_valid; i++) cyc();
    chk("mem_req_seen", mem_req_valid, 1);
  endtask

  task automatic req_hs();
    mem_req_ready = 1'b1;
    $display("mem_req id=%0d addr=%h", mem_req_id, mem_req_addr);
    cyc();
    mem_req_ready = 1'b0;
  endtask

  task automatic pop_and_drain();
    exp_t e;
    for (int i = 0; i < 50 && !refill_valid; i++) cyc();
    chk("refill_seen", refill_valid, 1);
    if (sbq.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk("refill_addr", refill_addr, e.addr);
      chk("refill_op", refill_op, e.op);
      chk("refill_way", refill_way, e.way);
      chk("refill_meta", refill_meta, e.meta);
      chk("refill_data", refill_data, e.data);
    end
    refill_ready = 1'b1;
    $display("refill addr=%h way=%0d meta=%0d", refill_addr, refill_way, refill_meta);
    cyc();
    refill_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{CACHE_OP_LOAD_REFILL,  32'h8000_0000, 2'd0, 32'h1111_1111, 32'h8000_0000, MPC_META_SHARE,  0};
    vecs[1] = '{CACHE_OP_STORE_REFILL, 32'h1234_567F, 2'd3, 32'h2222_2222, 32'h1234_5640, MPC_META_UNIQUE, 3};
    vecs[2] = '{CACHE_OP_LOAD_REFILL,  32'hFFFF_FFC1, 2'd1, 32'h3333_3333, 32'hFFFF_FFC0, MPC_META_SHARE,  1};
    vecs[3] = '{CACHE_OP_STORE_REFILL, 32'h0000_003F, 2'd2, 32'h4444_4444, 32'h0000_0000, MPC_META_UNIQUE, 0};
    vecs[4] = '{CACHE_OP_LOAD_REFILL,  32'hA5A5_A5BF, 2'd2, 32'h5555_5555, 32'hA5A5_A580, MPC_META_SHARE,  2};

    // Reset state
    cyc();
    chk("rst_miss_ready", miss_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_refill_valid", refill_valid, 0);
    chk("rst_lookup_hit", lookup_hit, 0);
    chk("rst_refill_data", refill_data, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_miss_ready", miss_ready, 1);

    // Single load miss with latency checks and a dropped beat for a REQ entry
    miss_valid = 1'b1; miss_op = CACHE_OP_LOAD_REFILL; miss_addr = 32'h0000_1040; miss_way = 2'd2;
    cyc();
    miss_valid = 1'b0;
    chk("t1_req_next_cycle", mem_req_valid, 1);
    chk("t1_req_addr", mem_req_addr, 32'h0000_1040);
    chk("t1_req_id", mem_req_id, 0);
    chk("t1_req_op", mem_req_op, MEM_OP_LOAD);
    mem_rsp_valid = 1'b1; mem_rsp_id = 2'd0; mem_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    cyc();
    mem_rsp_valid = 1'b0;
    req_hs();
    for (int b = 0; b < BEATS - 1; b++) send_beat(0, 32'hC0DE_0001, b);
    chk("t1_no_refill_early", refill_valid, 0);
    send_beat(0, 32'hC0DE_0001, BEATS - 1);
    chk("t1_refill_next_cycle", refill_valid, 1);
    sbq.push_back('{32'h0000_1040, CACHE_OP_LOAD_REFILL, 2'd2, MPC_META_SHARE, mk_line(0, 32'hC0DE_0001)});
    pop_and_drain();
    chk("t1_refill_gone", refill_valid, 0);

    // Table of single-line refills
    for (int v = 0; v < 5; v++) begin
      do_miss(vecs[v].op, vecs[v].addr, vecs[v].way);
      wait_req();
      chk("vec_req_addr", mem_req_addr, vecs[v].exp_addr);
      chk("vec_req_id", mem_req_id, 0);
      for (int d = 0; d < vecs[v].req_delay; d++) begin
        cyc();
        chk("vec_req_hold", mem_req_addr, vecs[v].exp_addr);
      end
      req_hs();
      sbq.push_back('{vecs[v].exp_addr, vecs[v].op, vecs[v].way, vecs[v].exp_meta, mk_line(0, vecs[v].seed)});
      feed_line(0, vecs[v].seed);
      pop_and_drain();
    end

    // Four misses back to back fill the buffer
    for (int k = 0; k < 4; k++) begin
      chk("t2_ready_before", miss_ready, 1);
      miss_valid = 1'b1;
      miss_op    = (k < 2) ? CACHE_OP_LOAD_REFILL : CACHE_OP_STORE_REFILL;
      miss_addr  = A0 + AW'(k * 64);
      miss_way   = WW'(k);
      cyc();
    end
    miss_valid = 1'b0;
    chk("t2_full_not_ready", miss_ready, 0);
    miss_valid = 1'b1; miss_addr = A4;
    cyc();
    miss_valid = 1'b0;
    for (int d = 0; d < 10; d++) begin
      chk("t4_req_id_stable", mem_req_id, 0);
      chk("t4_req_addr_stable", mem_req_addr, A0);
      cyc();
    end
    mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_issue_order", mem_req_id, k);
      cyc();
    end
    mem_req_ready = 1'b0;
    chk("t2_issue_done", mem_req_valid, 0);
    feed_line(2, 32'h0000_0222);
    chk("t2_refill_id2_addr", refill_addr, A2);
    chk("t2_refill_id2_data", refill_data, mk_line(2, 32'h0000_0222));
    chk("t2_refill_id2_meta", refill_meta, MPC_META_UNIQUE);
    refill_ready = 1'b1;
    chk("t2_ready_in_drain_cycle", miss_ready, 0);
    cyc();
    refill_ready = 1'b0;
    chk("t2_ready_after_drain", miss_ready, 1);
    do_miss(CACHE_OP_LOAD_REFILL, A4, 2'd0);
    chk("t2_fifth_id", mem_req_id, 2);
    chk("t2_fifth_addr", mem_req_addr, A4);
    req_hs();

    // Interleaved beats of ids 1 and 3
    sbq.push_back('{A1, CACHE_OP_LOAD_REFILL, 2'd1, MPC_META_SHARE, mk_line(1, 32'h0000_0111)});
    sbq.push_back('{A3, CACHE_OP_STORE_REFILL, 2'd3, MPC_META_UNIQUE, mk_line(3, 32'h0000_0333)});
    for (int b = 0; b < BEATS; b++) begin
      send_beat(1, 32'h0000_0111, b);
      if (b == BEATS - 1) chk("t3_id1_first", refill_addr, A1);
      send_beat(3, 32'h0000_0333, b);
    end
    for (int d = 0; d < 10; d++) begin
      chk("t4_refill_addr_stable", refill_addr, A1);
      chk("t4_refill_data_stable", refill_data, mk_line(1, 32'h0000_0111));
      cyc();
    end
    pop_and_drain();
    pop_and_drain();
    chk("t3_sb_empty", sbq.size(), 0);

    // Reset while ids 0 and 2 wait and id 1 has a pending request
    do_miss(CACHE_OP_LOAD_REFILL, A5, 2'd1);
    chk("t6_pending_req", mem_req_valid, 1);
    chk("t6_pending_id", mem_req_id, 1);
    rst = 1'b1;
    #1;
    chk("t6_req_valid_rst", mem_req_valid, 0);
    chk("t6_refill_valid_rst", refill_valid, 0);
    chk("t6_ready_rst", miss_ready, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_ready_after", miss_ready, 1);
    chk("t6_no_req_after", mem_req_valid, 0);

    // Store miss with lookup of the same line
    lookup_addr = 32'h2000_00BF;
    do_miss(CACHE_OP_STORE_REFILL, 32'h2000_0093, 2'd1);
    chk("t5_req_id", mem_req_id, 0);
    chk("t5_lookup_req", lookup_hit, LK_EN);
    lookup_addr = 32'h2000_0100;
    #1;
    chk("t5_lookup_other_line", lookup_hit, 0);
    lookup_addr = 32'h2000_0080;
    req_hs();
    feed_line(0, 32'h0000_0555);
    chk("t5_lookup_full", lookup_hit, LK_EN);
    sbq.push_back('{32'h2000_0080, CACHE_OP_STORE_REFILL, 2'd1, MPC_META_UNIQUE, mk_line(0, 32'h0000_0555)});
    pop_and_drain();
    chk("t5_lookup_after_drain", lookup_hit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
